// File: rtl/sdram_access_scheduler.sv
// Arbitrates CPU, video fetch and HSYNC-paced refresh onto one SDRAM command port, one word access at a time.
// Grant in IDLE, hold command until mem_ready, ack on mem_done; refresh debt accrues on HSYNC rising edges.
module sdram_access_scheduler #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int REF_PER_LINE = 2,
    parameter int DEBT_MAX     = 15,
    parameter int DEBT_URGENT  = 8,
    parameter int VID_RUN_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSYNC,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int DEBT_W = $clog2(DEBT_MAX + 1);
    localparam int RUN_W  = $clog2(VID_RUN_MAX + 1);
    localparam logic [DEBT_W+1:0] DEBT_INC = REF_PER_LINE[DEBT_W+1:0];
    localparam logic [DEBT_W-1:0] DEBT_SAT = DEBT_MAX[DEBT_W-1:0];
    localparam logic [DEBT_W-1:0] DEBT_HOT = DEBT_URGENT[DEBT_W-1:0];
    localparam logic [RUN_W-1:0]  RUN_SAT  = VID_RUN_MAX[RUN_W-1:0];

    localparam logic [1:0] CMD_READ    = 2'd0;
    localparam logic [1:0] CMD_WRITE   = 2'd1;
    localparam logic [1:0] CMD_REFRESH = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_REF} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [DEBT_W-1:0]   debt_q, debt_d;
    logic [RUN_W-1:0]    vid_run_q, vid_run_d;
    logic                hsync_q, hsync_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                vid_ack_q, vid_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;

    logic                grant_ref, grant_cpu, grant_vid, ref_done, hs_rise;
    logic [DEBT_W+1:0]   debt_sum;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        hsync_d     = HSYNC;
        vid_run_d   = vid_run_q;
        grant_ref   = 1'b0;
        grant_cpu   = 1'b0;
        grant_vid   = 1'b0;
        ref_done    = 1'b0;
        hs_rise     = HSYNC & ~hsync_q;

        case (state_q)
            S_IDLE: begin
                if (debt_q >= DEBT_HOT)                          grant_ref = 1'b1;
                else if (cpu_req && (vid_run_q >= RUN_SAT))      grant_cpu = 1'b1;
                else if (vid_req)                                grant_vid = 1'b1;
                else if (cpu_req)                                grant_cpu = 1'b1;
                else if (debt_q != '0)                           grant_ref = 1'b1;
            end
            S_ISSUE: begin
                if (mem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done) begin
                    state_d = S_IDLE;
                    if (owner_q == OWN_CPU) begin
                        cpu_ack_d   = 1'b1;
                        cpu_rdata_d = mem_rdata;
                    end else if (owner_q == OWN_VID) begin
                        vid_ack_d   = 1'b1;
                        vid_rdata_d = mem_rdata;
                    end else if (owner_q == OWN_REF) begin
                        ref_done    = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Command fields are captured at grant and stay frozen through ISSUE and WAIT.
        if (grant_ref) begin
            owner_d = OWN_REF;
            cmd_d   = CMD_REFRESH;
            addr_d  = '0;
            wdata_d = '0;
        end else if (grant_cpu) begin
            owner_d = OWN_CPU;
            cmd_d   = cpu_we ? CMD_WRITE : CMD_READ;
            addr_d  = cpu_addr;
            wdata_d = cpu_we ? cpu_wdata : '0;
        end else if (grant_vid) begin
            owner_d = OWN_VID;
            cmd_d   = CMD_READ;
            addr_d  = vid_addr;
            wdata_d = '0;
        end
        if (grant_ref || grant_cpu || grant_vid) state_d = S_ISSUE;

        if (grant_cpu || !cpu_req)                        vid_run_d = '0;
        else if (grant_vid && (vid_run_q < RUN_SAT))      vid_run_d = vid_run_q + 1'b1;

        // Wide sum so a coincident edge and completion net out before saturating.
        debt_sum = {2'b00, debt_q} + (hs_rise ? DEBT_INC : '0);
        if (ref_done) debt_sum = debt_sum - 1'b1;
        debt_d = (debt_sum > {2'b00, DEBT_SAT}) ? DEBT_SAT : debt_sum[DEBT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            debt_q      <= '0;
            vid_run_q   <= '0;
            hsync_q     <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            debt_q      <= debt_d;
            vid_run_q   <= vid_run_d;
            hsync_q     <= hsync_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_ack_q   <= vid_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    assign mem_valid = (state_q == S_ISSUE);
    assign mem_cmd   = cmd_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_ack   = vid_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;

endmodule

// File: tb/tb_sdram_access_scheduler.sv
// Randomized bench for sdram_access_scheduler: transaction-level arbitration model feeds a scoreboard,
// a bench-side sequencer answers commands, and a monitor checks every command and ack the DUT presents.
module tb_sdram_access_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        HSYNC = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [23:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        vid_req = 1'b0;
    logic [23:0] vid_addr = '0;
    logic        mem_ready = 1'b0;
    logic        mem_done = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        cpu_ack, vid_ack, mem_valid;
    logic [15:0] cpu_rdata, vid_rdata, mem_wdata;
    logic [1:0]  mem_cmd;
    logic [23:0] mem_addr;

    sdram_access_scheduler dut (
        .clk(clk), .rst(rst), .HSYNC(HSYNC),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] cmd; logic [23:0] addr; logic [15:0] wdata; } cmd_t;
    typedef struct packed { logic is_vid; logic [15:0] rdata; } ack_t;

    localparam int OWN_CPU = 1, OWN_VID = 2, OWN_REF = 3;

    cmd_t exp_cmd[$];
    ack_t exp_ack[$];
    cmd_t cur;
    int   tests = 0, fails = 0;

    // reference model state
    bit m_free = 1'b1, m_hs = 1'b0, chk_reset = 1'b0;
    int m_owner = 0, m_debt = 0, m_run = 0;

    // bench sequencer and stimulus knobs
    bit seq_busy = 1'b0, real_done = 1'b0;
    int seq_cnt = 0, vcyc = 0, hs_left = 0, rst_left = 3, reset_hits = 0;
    int p_cpu = 0, p_vid = 0, p_hs = 0, lat_min = 0, lat_max = 2;
    bit spur_en = 1'b0, drop_en = 1'b0, stall_mode = 1'b0, always_rdy = 1'b0, want_reset = 1'b0, t2_go = 1'b0;
    bit prev_valid = 1'b0, prev_hs = 1'b0;

    task automatic check(string name, int act, int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    function automatic int pick(int debt, int run, bit creq, bit vreq);
        if (debt >= 8)          return OWN_REF;
        if (creq && run >= 4)   return OWN_CPU;
        if (vreq)               return OWN_VID;
        if (creq)               return OWN_CPU;
        if (debt > 0)           return OWN_REF;
        return 0;
    endfunction

    // Advances the model over the clock edge that just passed, using the inputs held across it.
    task automatic model_step();
        int   g;
        bit   rise, rdone;
        cmd_t c;
        ack_t a;
        if (rst) begin
            m_free = 1'b1; m_debt = 0; m_run = 0; m_hs = 1'b0;
            exp_cmd.delete(); exp_ack.delete();
            chk_reset = 1'b1;
            return;
        end
        chk_reset = 1'b0;
        rise = HSYNC && !m_hs;
        m_hs = HSYNC;
        g = 0;
        rdone = 1'b0;
        if (!m_free) begin
            if (mem_done && real_done) begin
                m_free = 1'b1;
                if (m_owner == OWN_REF) rdone = 1'b1;
                else begin
                    a.is_vid = (m_owner == OWN_VID);
                    a.rdata  = mem_rdata;
                    exp_ack.push_back(a);
                end
            end
        end else begin
            g = pick(m_debt, m_run, cpu_req, vid_req);
            if (g != 0) begin
                m_free = 1'b0;
                m_owner = g;
                if (g == OWN_REF)      begin c.cmd = 2'd2; c.addr = '0; c.wdata = '0; end
                else if (g == OWN_VID) begin c.cmd = 2'd0; c.addr = vid_addr; c.wdata = '0; end
                else begin
                    c.cmd   = cpu_we ? 2'd1 : 2'd0;
                    c.addr  = cpu_addr;
                    c.wdata = cpu_we ? cpu_wdata : 16'h0;
                end
                exp_cmd.push_back(c);
            end
        end
        if (g == OWN_CPU || !cpu_req)        m_run = 0;
        else if (g == OWN_VID && m_run < 4)  m_run++;
        m_debt = m_debt + (rise ? 2 : 0) - (rdone ? 1 : 0);
        if (m_debt > 15) m_debt = 15;
    endtask

    // Driver: model first, then new inputs for the coming edge.
    always @(negedge clk) begin
        model_step();
        if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) rst = 1'b0;
        end else if (want_reset && seq_busy) begin
            rst = 1'b1; rst_left = 2; want_reset = 1'b0; reset_hits++;
        end
        if (rst) begin
            seq_busy = 1'b0; mem_done = 1'b0; real_done = 1'b0; mem_ready = 1'b0;
            cpu_req = 1'b0; vid_req = 1'b0; HSYNC = 1'b0; vcyc = 0;
        end else begin
            mem_done = 1'b0;
            real_done = 1'b0;
            if (seq_busy) begin
                if (seq_cnt == 0) begin
                    mem_done = 1'b1; real_done = 1'b1; mem_rdata = 16'($urandom); seq_busy = 1'b0;
                end else seq_cnt--;
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                mem_done = 1'b1; mem_rdata = 16'($urandom);
            end
            vcyc = mem_valid ? vcyc + 1 : 0;
            if (stall_mode)      mem_ready = (vcyc > 5);
            else if (always_rdy) mem_ready = 1'b1;
            else                 mem_ready = ($urandom_range(0, 3) != 0);
            if (mem_valid && mem_ready) begin
                seq_busy = 1'b1;
                seq_cnt  = $urandom_range(lat_min, lat_max);
            end

            if (cpu_ack) cpu_req = 1'b0;
            if (!cpu_req && t2_go) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h001234; cpu_wdata = 16'hBEEF; t2_go = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 99) < p_cpu) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 24'($urandom); cpu_wdata = 16'($urandom);
            end else if (cpu_req && !cpu_ack && drop_en && $urandom_range(0, 63) == 0) cpu_req = 1'b0;

            if (vid_ack) vid_req = 1'b0;
            if (!vid_req && $urandom_range(0, 99) < p_vid) begin
                vid_req = 1'b1; vid_addr = 24'($urandom);
            end else if (vid_req && !vid_ack && drop_en && $urandom_range(0, 63) == 0) vid_req = 1'b0;

            if (HSYNC)                                    HSYNC = 1'b0;
            else if (hs_left > 0)                         begin HSYNC = 1'b1; hs_left--; end
            else if ($urandom_range(0, 999) < p_hs)       HSYNC = 1'b1;
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clk) begin
        ack_t e;
        #1;
        if (chk_reset) begin
            check("rst_mem_valid", int'(mem_valid), 0);
            check("rst_cpu_ack",   int'(cpu_ack),   0);
            check("rst_vid_ack",   int'(vid_ack),   0);
            check("rst_mem_cmd",   int'(mem_cmd),   0);
            check("rst_mem_addr",  int'(mem_addr),  0);
            check("rst_mem_wdata", int'(mem_wdata), 0);
            check("rst_cpu_rdata", int'(cpu_rdata), 0);
            check("rst_vid_rdata", int'(vid_rdata), 0);
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) check("valid_after_handshake", int'(mem_valid), 0);
            if (mem_valid && (!prev_valid || prev_hs)) begin
                tests++;
                if (exp_cmd.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_cmd: got cmd %0d addr 0x%0h, required no command", mem_cmd, mem_addr);
                end else begin
                    cur = exp_cmd.pop_front();
                    check("cmd",       int'(mem_cmd),   int'(cur.cmd));
                    check("cmd_addr",  int'(mem_addr),  int'(cur.addr));
                    check("cmd_wdata", int'(mem_wdata), int'(cur.wdata));
                end
            end else if (mem_valid) begin
                check("stable_cmd",   int'(mem_cmd),   int'(cur.cmd));
                check("stable_addr",  int'(mem_addr),  int'(cur.addr));
                check("stable_wdata", int'(mem_wdata), int'(cur.wdata));
            end
            if (cpu_ack || vid_ack) begin
                tests++;
                if (exp_ack.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ack: got cpu_ack %0d vid_ack %0d, required none", cpu_ack, vid_ack);
                end else begin
                    e = exp_ack.pop_front();
                    check("ack_is_vid", int'(vid_ack), int'(e.is_vid));
                    check("ack_is_cpu", int'(cpu_ack), int'(!e.is_vid));
                    check("ack_rdata", e.is_vid ? int'(vid_rdata) : int'(cpu_rdata), int'(e.rdata));
                end
            end
            prev_valid = mem_valid;
            prev_hs    = mem_valid && mem_ready;
        end
    end

    task automatic drain(string name);
        bit ok;
        ok = 1'b0;
        p_cpu = 0; p_vid = 0; p_hs = 0; drop_en = 1'b0; spur_en = 1'b0;
        for (int i = 0; i < 800 && !ok; i++) begin
            @(negedge clk);
            #2;
            ok = m_free && (m_debt == 0) && !cpu_req && !vid_req && (hs_left == 0)
                 && (exp_cmd.size() == 0) && (exp_ack.size() == 0);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: not drained, got cmds %0d acks %0d debt %0d, required 0 0 0",
                     name, exp_cmd.size(), exp_ack.size(), m_debt);
        end
    endtask

    initial begin
        int hits;
        repeat (6) @(negedge clk);
        // single CPU write, done three cycles after the handshake
        always_rdy = 1'b1; lat_min = 2; lat_max = 2; t2_go = 1'b1;
        repeat (20) @(negedge clk);
        always_rdy = 1'b0; lat_min = 0; lat_max = 2;
        drain("single_write");
        // CPU and video both always requesting
        p_cpu = 100; p_vid = 100;
        repeat (200) @(negedge clk);
        drain("contention");
        // refresh from HSYNC with no requesters
        hs_left = 4;
        repeat (80) @(negedge clk);
        drain("refresh");
        // HSYNC burst with video held: urgent refresh and saturation
        p_vid = 100; hs_left = 10;
        repeat (200) @(negedge clk);
        drain("urgent");
        // long mem_ready stalls
        stall_mode = 1'b1; p_cpu = 50; p_vid = 50;
        repeat (200) @(negedge clk);
        drain("stall");
        stall_mode = 1'b0;
        // free-running mix with spurious done, drops and HSYNC
        p_cpu = 30; p_vid = 30; p_hs = 40; spur_en = 1'b1; drop_en = 1'b1; lat_max = 4;
        repeat (2500) @(negedge clk);
        // reset while a command is in WAIT
        hits = reset_hits;
        p_cpu = 100; lat_min = 3; lat_max = 6; want_reset = 1'b1;
        for (int i = 0; i < 300 && want_reset; i++) @(negedge clk);
        check("reset_mid_wait_applied", reset_hits, hits + 1);
        want_reset = 1'b0; lat_min = 0; lat_max = 3;
        repeat (100) @(negedge clk);
        drain("final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
